free_list: RTL

Physical-register free list feeding the rename stage. Supplies up to two free physical register tags per cycle for the rename alias table's write ports, and accepts up to two released tags per cycle from commit. Snapshots its head pointer alongside each alias-table checkpoint and rewinds it on misprediction restore, so speculatively allocated tags return to the pool.

---
 rtl/free_list.sv | 121 ++++++++++++
 1 files changed

// File: rtl/free_list.sv
// Physical-register free list: two allocations and two releases per cycle, with head checkpoints for rename rollback.
// Optional FREE_LIST_ERR_EN enables the sticky err flag and simulation assertions; err is tied 0 otherwise.
module free_list #(
  parameter  int P_ADDR_WIDTH = 7,
  parameter  int L_ADDR_WIDTH = 5,
  parameter  int C_NUM        = 2,
  localparam int DEPTH        = 2**P_ADDR_WIDTH - 2**L_ADDR_WIDTH,
  localparam int CNT_W        = $clog2(DEPTH+1),
  localparam int ID_W         = $clog2(C_NUM)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    pop_en_1,
  input  logic                    pop_en_2,
  output logic [P_ADDR_WIDTH-1:0] pop_data_1,
  output logic [P_ADDR_WIDTH-1:0] pop_data_2,
  output logic [CNT_W-1:0]        free_count,
  output logic                    can_pop_2,
  input  logic                    push_en_1,
  input  logic                    push_en_2,
  input  logic [P_ADDR_WIDTH-1:0] push_data_1,
  input  logic [P_ADDR_WIDTH-1:0] push_data_2,
  input  logic                    take_checkpoint,
  input  logic                    dual_branch,
  input  logic                    instr_num,
  input  logic [ID_W-1:0]         ckp_id,
  input  logic                    restore,
  input  logic [ID_W-1:0]         restore_id,
  output logic                    err
);
  localparam int PW = $clog2(2*DEPTH);
  localparam int IW = $clog2(DEPTH);
  typedef logic [PW-1:0] ptr_t;
  localparam ptr_t          DEPTH_P = ptr_t'(DEPTH);
  localparam logic [PW:0]   TWO_D   = (PW+1)'(2*DEPTH);
  localparam logic [ID_W-1:0] LAST_ID = ID_W'(C_NUM-1);

  logic [P_ADDR_WIDTH-1:0] mem [DEPTH];
  ptr_t head, tail, head_nxt, h1, h2, fc;
  ptr_t ckp [C_NUM];
  logic [1:0] n_pop, n_push;
  logic pop_ok, push_ok;
  logic [ID_W-1:0] ckp_nxt;

  // Pointers carry a lap bit: they run 0..2*DEPTH-1 so full and empty differ.
  function automatic ptr_t ptr_add(ptr_t p, logic [1:0] n);
    logic [PW:0] s;
    s = {1'b0, p} + (PW+1)'(n);
    if (s >= TWO_D) s = s - TWO_D;
    return s[PW-1:0];
  endfunction

  function automatic logic [IW-1:0] idx(ptr_t p);
    return (p >= DEPTH_P) ? IW'(p - DEPTH_P) : IW'(p);
  endfunction

  always_comb begin
    fc = (tail >= head) ? tail - head : ptr_t'({1'b0, tail} + TWO_D - {1'b0, head});
    n_pop   = {1'b0, pop_en_1} + {1'b0, pop_en_2};
    n_push  = {1'b0, push_en_1} + {1'b0, push_en_2};
    pop_ok  = fc >= ptr_t'(n_pop);
    push_ok = ({1'b0, fc} + (PW+1)'(n_push)) <= {1'b0, DEPTH_P};
    h1 = pop_ok ? ptr_add(head, {1'b0, pop_en_1}) : head;
    h2 = pop_ok ? ptr_add(head, n_pop) : head;
    head_nxt = restore ? ckp[restore_id] : h2;
    ckp_nxt  = (ckp_id == LAST_ID) ? '0 : ckp_id + ID_W'(1);
  end

  assign pop_data_1 = mem[idx(head)];
  assign pop_data_2 = pop_en_1 ? mem[idx(ptr_add(head, 2'd1))] : pop_data_1;
  assign free_count = fc[CNT_W-1:0];
  assign can_pop_2  = fc >= ptr_t'(2);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head <= '0;
      tail <= DEPTH_P;
      for (int i = 0; i < C_NUM; i++) ckp[i] <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= P_ADDR_WIDTH'(2**L_ADDR_WIDTH + i);
    end else begin
      head <= head_nxt;
      if (push_ok) begin
        tail <= ptr_add(tail, n_push);
        if (push_en_1) mem[idx(tail)] <= push_data_1;
        // A lone push_en_2 compacts into the tail slot.
        if (push_en_2) mem[push_en_1 ? idx(ptr_add(tail, 2'd1)) : idx(tail)] <= push_data_2;
      end
      if (!restore && take_checkpoint) begin
        if (dual_branch) begin
          ckp[ckp_id]  <= h1;
          ckp[ckp_nxt] <= h2;
        end else begin
          ckp[ckp_id] <= instr_num ? h2 : h1;
        end
      end
    end
  end

`ifdef FREE_LIST_ERR_EN
  localparam logic [P_ADDR_WIDTH-1:0] LOW_TAG = P_ADDR_WIDTH'(2**L_ADDR_WIDTH);
  logic pop_drop, push_drop, bad_tag;
  assign pop_drop  = !pop_ok && !restore;
  assign push_drop = !push_ok;
  assign bad_tag   = (push_en_1 && push_data_1 < LOW_TAG) || (push_en_2 && push_data_2 < LOW_TAG);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) err <= 1'b0;
    else if (pop_drop || push_drop || bad_tag) err <= 1'b1;
  end

  a_pop_drop:  assert property (@(posedge clk) disable iff (!rst_n) !pop_drop)
    else $warning("free_list: pop dropped, not enough free tags");
  a_push_drop: assert property (@(posedge clk) disable iff (!rst_n) !push_drop)
    else $warning("free_list: push dropped, list already full");
  a_bad_tag:   assert property (@(posedge clk) disable iff (!rst_n) !bad_tag)
    else $warning("free_list: released tag maps to an architectural register");
`else
  assign err = 1'b0;
`endif

endmodule
